fetch_stage: RTL and testbench
==============================

// Module: fetch_stage
// PURPOSE
//  Next-generation instruction fetch: PC register, instr_mem ROM and a registered output stage with valid/ready handshake.
//  Adds an explicit run state machine, downstream stall, wrong-path squash on taken branches, halt, and restart while running.
//  Sits between the top-level start/branch control and the decode stage of the emulated core.
// PARAMETERS
//  rom_size      512  instruction ROM depth in words (power of two)
//  instr_width   9    instruction word width
//  target_width  8    branch target / offset width
//  aw (localparam) = $clog2(rom_size)+1 ; PC and address width
// PORTS
//  clk          in   1             rising-edge clock
//  rst_n        in   1             asynchronous active-low reset
//  start        in   1             begin (or restart) fetching at start_addr
//  start_addr   in   aw            first PC after start
//  halt         in   1             stop fetching, return to IDLE
//  branch       in   1             a branch resolved this cycle
//  taken        in   1             resolved branch is taken (qualified by branch)
//  target       in   target_width  branch target (absolute or offset, see CONFIGURATION)
//  instr_ready  in   1             decode accepts instr_out this cycle
//  instr_valid  out  1             instr_out/pc_out hold a valid instruction
//  instr_out    out  instr_width   fetched instruction word (registered)
//  pc_out       out  aw            address of instr_out (registered)
//  busy         out  1             state == FETCH
// BEHAVIOUR
//  - Reset (async, rst_n=0): state=IDLE, pc=0, instr_valid=0, instr_out=0, pc_out=0, busy=0, acc_pc=0. Takes effect immediately, mid-fetch included.
//  - States: IDLE -> FETCH on start; FETCH -> IDLE on halt (start wins over halt); FETCH -> FETCH on start (restart).
//  - ROM read is combinational on pc; result captured into the output register -> 1-cycle latency from pc to instr_out.
//  - Load condition (FETCH only): load = !instr_valid || instr_ready. On load: instr_out<=rom[pc], pc_out<=pc, instr_valid<=1, pc<=pc+1.
//  - Handoff: instr_valid && instr_ready = accepted; acc_pc<=pc_out. instr_valid && !instr_ready: instr_out, pc_out, pc all hold (stall).
//  - Taken branch (branch && taken, FETCH): pc<=branch target; instr_valid<=0 (squash wrong-path word), no load that cycle;
//    first target instruction valid 1 cycle later. branch && !taken: no effect. taken without branch: ignored.
//  - Priority per cycle: rst_n > start > halt > taken branch > normal load/stall.
//  - start (any state): pc<=start_addr, instr_valid<=0, state<=FETCH; first instruction valid the cycle after.
//  - halt in FETCH: instr_valid<=0, pc holds, state<=IDLE. halt in IDLE: no effect.
//  - IDLE: no loads, instr_valid stays 0, pc holds; branch/taken ignored.
//  - PC arithmetic modulo 2^aw: pc=2^aw-1 increments to 0. Addresses >= rom_size read as all-zero words (NOP).
//  - Absolute target zero-extended to aw bits.
// CONFIGURATION
//  FETCH_REL_BRANCH_EN defined: target is a signed two's-complement offset; new pc = acc_pc + sext(target) mod 2^aw,
//    acc_pc = PC of the most recently accepted instruction (the branch itself).
//  Not defined: target is absolute; new pc = zext(target). acc_pc register may be omitted.
// TESTING
//  1 Reset, start=1 start_addr=0 one cycle, instr_ready=1 -> instr_valid rises next cycle, pc_out=0,1,2,... one per cycle, instr_out=rom[pc_out].
//  2 Streaming, hold instr_ready=0 3 cycles at pc_out=5 -> instr_out/pc_out frozen at 5; ready=1 -> 6 next cycle, no word lost or duplicated.
//  3 Accept pc_out=10, branch=1 taken=1 target=40 (abs) -> next cycle instr_valid=0, following cycle pc_out=40; REL_EN target=8'hFE -> pc_out=8.
//  4 branch=1 taken=0 at pc_out=20 -> sequence continues 21,22 unchanged; start and halt same cycle -> restart at start_addr, busy=1.
//  5 Start at start_addr=2^aw-2 -> pc_out 2^aw-2, 2^aw-1, 0; words for addresses >= rom_size read 0.
//  6 Drop rst_n mid-stall -> instr_valid, pc_out, instr_out, busy go 0 without a clock edge; fetch resumes only after new start.

Source files
------------

// File: rtl/fetch_stage.sv
// fetch_stage: instruction fetch with PC register, combinational instruction
// ROM and a registered output stage using a valid/ready handshake. A run FSM
// (IDLE/FETCH) gates fetching. Taken branches squash the word in flight, and
// start/halt restart or stop the stream.
// Optional feature: define FETCH_REL_BRANCH_EN to treat target as a signed
// offset from the PC of the most recently accepted instruction. When it is
// undefined, target is an absolute, zero-extended address.
// ROM contents: word(a) = (a*37 + 11) truncated to instr_width bits for
// a < rom_size. Any address >= rom_size reads as zero (NOP).
module fetch_stage #(
    parameter int rom_size     = 512,
    parameter int instr_width  = 9,
    parameter int target_width = 8,
    localparam int aw          = $clog2(rom_size) + 1
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic                    start,
    input  logic [aw-1:0]           start_addr,
    input  logic                    halt,
    input  logic                    branch,
    input  logic                    taken,
    input  logic [target_width-1:0] target,
    input  logic                    instr_ready,
    output logic                    instr_valid,
    output logic [instr_width-1:0]  instr_out,
    output logic [aw-1:0]           pc_out,
    output logic                    busy
);

    typedef enum logic {IDLE = 1'b0, FETCH = 1'b1} state_t;

    state_t                 state_q, state_d;
    logic [aw-1:0]          pc_q, pc_d;
    logic [aw-1:0]          pc_out_q, pc_out_d;
    logic [instr_width-1:0] instr_q, instr_d;
    logic                   valid_q, valid_d;
    logic                   accept;
    logic                   take_branch;
    logic                   load;
    logic [aw-1:0]          target_pc;

    // Instruction ROM contents; out-of-range addresses return a NOP
    function automatic logic [instr_width-1:0] rom_word(input logic [aw-1:0] addr);
        logic [31:0] t;
        t = 32'(addr) * 32'd37 + 32'd11;
        if (32'(addr) >= 32'(rom_size)) rom_word = '0;
        else                            rom_word = t[instr_width-1:0];
    endfunction

    // Handshake and branch qualifiers shared by all next-state logic
    always_comb begin
        accept      = valid_q && instr_ready;
        take_branch = branch && taken;
        load        = !valid_q || instr_ready;
    end

`ifdef FETCH_REL_BRANCH_EN
    logic [aw-1:0]        acc_pc_q, acc_pc_d;
    logic signed [aw-1:0] offset;

    // The branch is the word being accepted now, so forward pc_out when accepting
    always_comb begin
        acc_pc_d  = accept ? pc_out_q : acc_pc_q;
        offset    = {{(aw-target_width){target[target_width-1]}}, target};
        target_pc = acc_pc_d + offset;
    end

    // Track the PC of the most recently accepted instruction
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) acc_pc_q <= '0;
        else        acc_pc_q <= acc_pc_d;
    end
`else
    // Absolute branch target, zero-extended to the PC width
    always_comb begin
        target_pc = {{(aw-target_width){1'b0}}, target};
    end
`endif

    // Run FSM next state: start wins over halt and also restarts from FETCH
    always_comb begin
        state_d = state_q;
        if (start)                          state_d = FETCH;
        else if (state_q == FETCH && halt)  state_d = IDLE;
    end

    // PC and output register next values, by priority start > halt > branch > load
    always_comb begin
        pc_d     = pc_q;
        pc_out_d = pc_out_q;
        instr_d  = instr_q;
        valid_d  = valid_q;
        if (start) begin
            pc_d    = start_addr;
            valid_d = 1'b0;
        end else if (state_q == FETCH) begin
            if (halt) begin
                valid_d = 1'b0;
            end else if (take_branch) begin
                pc_d    = target_pc;
                valid_d = 1'b0;
            end else if (load) begin
                instr_d  = rom_word(pc_q);
                pc_out_d = pc_q;
                valid_d  = 1'b1;
                pc_d     = pc_q + aw'(1);
            end
        end
    end

    // State, PC and output registers with asynchronous clear
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= IDLE;
            pc_q     <= '0;
            pc_out_q <= '0;
            instr_q  <= '0;
            valid_q  <= 1'b0;
        end else begin
            state_q  <= state_d;
            pc_q     <= pc_d;
            pc_out_q <= pc_out_d;
            instr_q  <= instr_d;
            valid_q  <= valid_d;
        end
    end

    // Outputs come straight from registers; busy decodes the run state
    always_comb begin
        instr_valid = valid_q;
        instr_out   = instr_q;
        pc_out      = pc_out_q;
        busy        = (state_q == FETCH);
    end

endmodule

// File: tb/tb_fetch_stage.sv
// tb_fetch_stage: directed bench for fetch_stage with a cycle model of the
// fetch rules and per-cycle comparison, plus literal expectations.
module tb_fetch_stage;

    localparam int AW = 10;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       start, halt, branch, taken, instr_ready;
    logic [9:0] start_addr;
    logic [7:0] target;
    logic       instr_valid, busy;
    logic [8:0] instr_out;
    logic [9:0] pc_out;

    int checks   = 0;
    int failures = 0;

    fetch_stage dut (
        .clk(clk), .rst_n(rst_n), .start(start), .start_addr(start_addr),
        .halt(halt), .branch(branch), .taken(taken), .target(target),
        .instr_ready(instr_ready), .instr_valid(instr_valid),
        .instr_out(instr_out), .pc_out(pc_out), .busy(busy)
    );

    always #5 clk = ~clk;

    function automatic int rom_m(input int a);
        if (a < 512) return (a * 37 + 11) % 512;
        return 0;
    endfunction

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            failures++;
            $display("FAIL %s actual=%0d expected=%0d at %0t", name, act, exp, $time);
        end
    endtask

    // Behavioural model: what a fetch unit must present after each edge
    int m_run = 0, m_pc = 0, m_valid = 0, m_instr = 0, m_pc_out = 0, m_acc = 0;

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            m_run = 0; m_pc = 0; m_valid = 0; m_instr = 0; m_pc_out = 0; m_acc = 0;
        end else begin
            if (m_valid != 0 && instr_ready) m_acc = m_pc_out;
            if (start) begin
                m_run = 1; m_pc = int'(start_addr); m_valid = 0;
            end else if (m_run != 0) begin
                if (halt) begin
                    m_run = 0; m_valid = 0;
                end else if (branch && taken) begin
`ifdef FETCH_REL_BRANCH_EN
                    int off;
                    off  = (int'(target) >= 128) ? int'(target) - 256 : int'(target);
                    m_pc = (m_acc + off + 1024) % 1024;
`else
                    m_pc = int'(target);
`endif
                    m_valid = 0;
                end else if (m_valid == 0 || instr_ready) begin
                    m_instr  = rom_m(m_pc);
                    m_pc_out = m_pc;
                    m_valid  = 1;
                    m_pc     = (m_pc + 1) % 1024;
                end
            end
        end
    end

    // Compare DUT against the model every cycle outside reset
    always @(negedge clk) begin
        if (rst_n) begin
            chk("m_valid", int'(instr_valid), m_valid);
            chk("m_busy", int'(busy), m_run);
            if (m_valid != 0) begin
                chk("m_pc_out", int'(pc_out), m_pc_out);
                chk("m_instr", int'(instr_out), m_instr);
            end
        end
    end

    task automatic wait_pc(input int p, input int bound);
        int found = 0;
        for (int i = 0; i < bound; i++) begin
            if (instr_valid && int'(pc_out) == p) begin
                found = 1;
                break;
            end
            @(negedge clk);
        end
        chk("wait_pc", found, 1);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog actual=timeout required=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        rst_n = 1'b0; start = 0; halt = 0; branch = 0; taken = 0;
        instr_ready = 0; start_addr = '0; target = '0;
        #2;
        chk("rst_valid", int'(instr_valid), 0);
        chk("rst_pc_out", int'(pc_out), 0);
        chk("rst_instr", int'(instr_out), 0);
        chk("rst_busy", int'(busy), 0);
        @(negedge clk); @(negedge clk);
        rst_n = 1'b1;

        // Start at 0 and stream
        start = 1; start_addr = 10'd0; instr_ready = 1;
        @(negedge clk); start = 0;
        chk("t1_valid_late", int'(instr_valid), 0);
        chk("t1_busy", int'(busy), 1);
        @(negedge clk);
        chk("t1_valid", int'(instr_valid), 1);
        chk("t1_pc0", int'(pc_out), 0);
        chk("t1_i0", int'(instr_out), 11);
        @(negedge clk);
        chk("t1_pc1", int'(pc_out), 1);
        chk("t1_i1", int'(instr_out), 48);
        @(negedge clk);
        chk("t1_pc2", int'(pc_out), 2);
        chk("t1_i2", int'(instr_out), 85);

        // Stall three cycles at pc_out=5
        wait_pc(5, 20);
        instr_ready = 0;
        repeat (3) begin
            @(negedge clk);
            chk("t2_hold_pc", int'(pc_out), 5);
            chk("t2_hold_i", int'(instr_out), 196);
            chk("t2_hold_v", int'(instr_valid), 1);
        end
        instr_ready = 1;
        @(negedge clk);
        chk("t2_pc6", int'(pc_out), 6);
        chk("t2_i6", int'(instr_out), 233);

        // Taken branch while the branch word at pc_out=10 is accepted
        wait_pc(10, 20);
        branch = 1; taken = 1;
`ifdef FETCH_REL_BRANCH_EN
        target = 8'hFE;
`else
        target = 8'd40;
`endif
        @(negedge clk); branch = 0; taken = 0;
        chk("t3_squash", int'(instr_valid), 0);
        @(negedge clk);
        chk("t3_valid", int'(instr_valid), 1);
`ifdef FETCH_REL_BRANCH_EN
        chk("t3_pc", int'(pc_out), 8);
        chk("t3_i", int'(instr_out), 307);
`else
        chk("t3_pc", int'(pc_out), 40);
        chk("t3_i", int'(instr_out), 467);
`endif

        // Not-taken branch, taken without branch, start+halt together
        start = 1; start_addr = 10'd15;
        @(negedge clk); start = 0;
        wait_pc(20, 20);
        branch = 1; taken = 0;
        @(negedge clk); branch = 0;
        chk("t4_pc21", int'(pc_out), 21);
        taken = 1;
        @(negedge clk); taken = 0;
        chk("t4_pc22", int'(pc_out), 22);
        start = 1; halt = 1; start_addr = 10'd100;
        @(negedge clk); start = 0; halt = 0;
        chk("t4_restart_v", int'(instr_valid), 0);
        chk("t4_restart_busy", int'(busy), 1);
        @(negedge clk);
        chk("t4_pc100", int'(pc_out), 100);
        chk("t4_busy", int'(busy), 1);
        halt = 1;
        @(negedge clk); halt = 0;
        chk("t4_halt_busy", int'(busy), 0);
        chk("t4_halt_v", int'(instr_valid), 0);
        branch = 1; taken = 1; target = 8'd50;
        @(negedge clk); branch = 0; taken = 0;
        @(negedge clk);
        chk("t4_idle_v", int'(instr_valid), 0);
        chk("t4_idle_busy", int'(busy), 0);

        // PC wrap and out-of-range ROM reads
        start = 1; start_addr = 10'd1022;
        @(negedge clk); start = 0;
        @(negedge clk);
        chk("t5_pc1022", int'(pc_out), 1022);
        chk("t5_i1022", int'(instr_out), 0);
        @(negedge clk);
        chk("t5_pc1023", int'(pc_out), 1023);
        chk("t5_i1023", int'(instr_out), 0);
        @(negedge clk);
        chk("t5_pc0", int'(pc_out), 0);
        chk("t5_i0", int'(instr_out), 11);

        // Asynchronous reset in the middle of a stall
        instr_ready = 0;
        repeat (2) @(negedge clk);
        #3 rst_n = 1'b0;
        #1;
        chk("t6_valid", int'(instr_valid), 0);
        chk("t6_pc_out", int'(pc_out), 0);
        chk("t6_instr", int'(instr_out), 0);
        chk("t6_busy", int'(busy), 0);
        @(negedge clk); @(negedge clk);
        rst_n = 1'b1; instr_ready = 1;
        repeat (3) begin
            @(negedge clk);
            chk("t6_idle_v", int'(instr_valid), 0);
            chk("t6_idle_busy", int'(busy), 0);
        end
        start = 1; start_addr = 10'd3;
        @(negedge clk); start = 0;
        @(negedge clk);
        chk("t6_pc3", int'(pc_out), 3);
        chk("t6_i3", int'(instr_out), 122);

        @(negedge clk);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
